// File: rtl/block_tile_scheduler.sv
// Tile sequencer for the blocked matmul path: walks (row, col, k) tiles,
// hands each one to the MAC array and strobes the accumulator once per tile.
module block_tile_scheduler #(
  parameter int NUM_BLOCKS = 2,
  parameter int IDX_WIDTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 tile_valid,
  input  logic                 tile_ready,
  output logic [IDX_WIDTH-1:0] k_block_idx,
  input  logic                 mac_done,
  output logic                 accumulate_result,
  output logic [IDX_WIDTH-1:0] row_block_idx,
  output logic [IDX_WIDTH-1:0] col_block_idx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] tile_count,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_MAC,
    ACCUM,
    GAP,
    FINISH
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_BLOCKS - 1);

  state_t state;
  state_t state_nxt;
  logic   last_tile;

  assign last_tile = (row_block_idx == LAST) &&
                     (col_block_idx == LAST) &&
                     (k_block_idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs decode straight from state so reset clears them immediately.
  always_comb begin
    state_nxt         = state;
    tile_valid        = 1'b0;
    accumulate_result = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        tile_valid = 1'b1;
        busy       = 1'b1;
        if (tile_ready) state_nxt = WAIT_MAC;
      end
      WAIT_MAC: begin
        busy = 1'b1;
        if (mac_done) state_nxt = ACCUM;
      end
      ACCUM: begin
        accumulate_result = 1'b1;
        busy              = 1'b1;
        state_nxt         = GAP;
      end
      GAP: begin
        busy      = 1'b1;
        state_nxt = last_tile ? FINISH : ISSUE;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_block_idx <= '0;
      col_block_idx <= '0;
      k_block_idx   <= '0;
      tile_count    <= '0;
      cycle_count   <= '0;
    end else begin
      if (state == IDLE) begin
        if (start) begin
          row_block_idx <= '0;
          col_block_idx <= '0;
          k_block_idx   <= '0;
          tile_count    <= '0;
          cycle_count   <= '0;
        end
      end else if (cycle_count != '1) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if (state == ACCUM) tile_count <= tile_count + 1'b1;
      // k innermost, then col, then row; the last tile leaves indices parked
      if (state == GAP && !last_tile) begin
        if (k_block_idx == LAST) begin
          k_block_idx <= '0;
          if (col_block_idx == LAST) begin
            col_block_idx <= '0;
            row_block_idx <= row_block_idx + 1'b1;
          end else begin
            col_block_idx <= col_block_idx + 1'b1;
          end
        end else begin
          k_block_idx <= k_block_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/block_tile_scheduler.md
Name: block_tile_scheduler

Overview:
- Sequencer directly upstream of the result accumulator in the blocked 128x128 matrix-multiply path.
- Walks every (row block, col block, k block) tile triple and issues each tile to the MAC array with a valid/ready handshake.
- Waits for MAC completion, then drives the accumulate_result level, with row_block_idx and col_block_idx held stable, so the accumulator's rising-edge detector folds in one partial product per tile.
- Signals overall completion once all tiles have been accumulated.

Parameters:
- NUM_BLOCKS, 2, blocks per matrix dimension (MATRIX_SIZE/BLOCK_SIZE); legal range 1..4.
- IDX_WIDTH, 2, width of each block index output; must satisfy 2**IDX_WIDTH >= NUM_BLOCKS.
- CNT_WIDTH, 16, width of the tile and cycle counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a full matmul; sampled only in IDLE.
- tile_valid  out  1  tile request to the MAC array.
- tile_ready  in  1  MAC array accepts the tile.
- k_block_idx  out  IDX_WIDTH  inner-dimension block of the current tile.
- mac_done  in  1  MAC array finished the accepted tile; block_result is valid.
- accumulate_result  out  1  accumulator strobe.
- row_block_idx  out  IDX_WIDTH  output row block of the current tile.
- col_block_idx  out  IDX_WIDTH  output column block of the current tile.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last accumulation.
- tile_count  out  CNT_WIDTH  number of tiles accumulated since the last start.
- cycle_count  out  CNT_WIDTH  clock cycles elapsed since the last start; saturates at all-ones.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE.
  - All outputs 0: tile_valid, accumulate_result, busy, done, all indices, tile_count, cycle_count.
- States: IDLE, ISSUE, WAIT_MAC, ACCUM, GAP, FINISH.
- IDLE:
  - start=1 -> ISSUE.
  - Indices cleared to (0,0,0); tile_count and cycle_count cleared to 0; busy=1 from the next cycle.
- ISSUE:
  - tile_valid=1; all three indices stable.
  - tile_valid&&tile_ready at an edge -> WAIT_MAC; tile_valid drops in the same cycle WAIT_MAC is entered.
- WAIT_MAC:
  - mac_done=1 -> ACCUM.
  - mac_done in any other state is ignored.
- ACCUM:
  - accumulate_result=1 for exactly one cycle; indices unchanged; tile_count increments.
- GAP:
  - accumulate_result=0 for exactly one cycle; this guarantees a fresh rising edge for the next tile.
  - At the end of GAP, indices advance with k innermost, then col, then row.
  - If (row,col,k) was (NUM_BLOCKS-1, NUM_BLOCKS-1, NUM_BLOCKS-1) -> FINISH; otherwise -> ISSUE.
- FINISH:
  - done=1 for one cycle, busy=0, then -> IDLE.
  - Indices hold their last values; tile_count and cycle_count hold until the next start.
- Index wrap:
  - k wraps to 0 and carries into col.
  - col wraps to 0 and carries into row.
  - No index ever reaches NUM_BLOCKS.
- start while not in IDLE is ignored: no restart, no error.
- cycle_count increments every cycle while busy and saturates at 2**CNT_WIDTH-1.
- Minimum per-tile latency (tile_ready and mac_done held high): 4 cycles (ISSUE, WAIT_MAC, ACCUM, GAP).
  - NUM_BLOCKS=2 gives 8 tiles = 32 cycles, then 1 FINISH cycle.
- Invariant: accumulate_result is never high in two consecutive cycles.
- Invariant: tile_valid and accumulate_result are never high together.

Test Plan:
- Reset release, no start for 20 cycles -> all outputs stay 0; state remains IDLE.
- NUM_BLOCKS=2, tile_ready=1, mac_done=1 constant, 1-cycle start pulse ->
  - 8 accumulate pulses, spaced 4 cycles apart.
  - (row,col,k) sequence: (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0),(1,0,1),(1,1,0),(1,1,1).
  - done pulses 1 cycle after the final GAP; tile_count=8; cycle_count=33.
- tile_ready held low 5 cycles on tile 3 ->
  - tile_valid stays high with indices (0,1,0) stable throughout.
  - No accumulate pulse during the stall; total cycle_count=38.
- mac_done pulsed during ISSUE and GAP, then correctly in WAIT_MAC -> early pulses ignored; exactly one accumulate per tile.
- start re-asserted mid-run at tile 4 -> ignored; sequence and the final tile_count=8 are unchanged.
- rst asserted while in ACCUM on tile 5 -> accumulate_result, busy and indices drop to 0 immediately (asynchronously); a subsequent start restarts cleanly at (0,0,0).
